// File: rtl/generador_sensores.sv
// Parking-lot barrier stimulus generator: walks the active-low a/b lines
// through entry/exit patterns and keeps a saturating reference car count.
module generador_sensores #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_entrada,
  input  logic       req_salida,
  input  logic       abortar,
  output logic       a,
  output logic       b,
  output logic       ocupado,
  output logic       fin,
  output logic       abortado,
  output logic [2:0] autos
);

  typedef enum logic [2:0] {
    REPOSO,
    FASE1,
    FASE2,
    FASE3,
    RETRO,
    PAUSA
  } estado_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  estado_t    estado;
  logic       dir;
  logic [1:0] fase_ret;
  logic [7:0] cnt;
  logic [1:0] fase_act;
  logic       hold_fin;
  logic       gap_fin;

  // Line pattern {a,b} for phase k of a direction; k=0 is beam clear.
  function automatic logic [1:0] patron(
    input logic       d,
    input logic [1:0] k
  );
    logic [1:0] ab;
    ab = 2'b11;
    case (k)
      2'd1:    ab = d ? 2'b10 : 2'b01;
      2'd2:    ab = 2'b00;
      2'd3:    ab = d ? 2'b01 : 2'b10;
      default: ab = 2'b11;
    endcase
    return ab;
  endfunction

  always_comb begin
    fase_act = 2'd1;
    case (estado)
      FASE2:   fase_act = 2'd2;
      FASE3:   fase_act = 2'd3;
      default: fase_act = 2'd1;
    endcase
  end

  assign hold_fin = (cnt == HOLD_LAST);
  assign gap_fin  = (cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= REPOSO;
      dir      <= 1'b0;
      fase_ret <= 2'd0;
      cnt      <= 8'd0;
      a        <= 1'b1;
      b        <= 1'b1;
      ocupado  <= 1'b0;
      fin      <= 1'b0;
      abortado <= 1'b0;
      autos    <= 3'd0;
    end else begin
      fin      <= 1'b0;
      abortado <= 1'b0;
      unique case (estado)
        REPOSO: begin
          cnt <= 8'd0;
          if (req_entrada || req_salida) begin
            // entry wins when both are requested
            dir     <= ~req_entrada;
            estado  <= FASE1;
            ocupado <= 1'b1;
            {a, b}  <= patron(~req_entrada, 2'd1);
          end
        end
        FASE1, FASE2, FASE3: begin
          if (abortar) begin
            cnt <= 8'd0;
            if (fase_act == 2'd1) begin
              estado   <= PAUSA;
              fase_ret <= 2'd0;
              {a, b}   <= 2'b11;
              abortado <= 1'b1;
            end else begin
              estado   <= RETRO;
              fase_ret <= fase_act - 2'd1;
              {a, b}   <= patron(dir, fase_act - 2'd1);
            end
          end else if (hold_fin) begin
            cnt <= 8'd0;
            if (fase_act == 2'd3) begin
              estado <= PAUSA;
              {a, b} <= 2'b11;
              fin    <= 1'b1;
              if (!dir && autos != 3'd7)
                autos <= autos + 3'd1;
              else if (dir && autos != 3'd0)
                autos <= autos - 3'd1;
            end else begin
              estado <= (fase_act == 2'd1) ? FASE2 : FASE3;
              {a, b} <= patron(dir, fase_act + 2'd1);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RETRO: begin
          if (hold_fin) begin
            cnt <= 8'd0;
            if (fase_ret == 2'd1) begin
              estado   <= PAUSA;
              fase_ret <= 2'd0;
              {a, b}   <= 2'b11;
              abortado <= 1'b1;
            end else begin
              fase_ret <= fase_ret - 2'd1;
              {a, b}   <= patron(dir, fase_ret - 2'd1);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PAUSA: begin
          if (gap_fin) begin
            cnt     <= 8'd0;
            estado  <= REPOSO;
            ocupado <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          estado  <= REPOSO;
          cnt     <= 8'd0;
          {a, b}  <= 2'b11;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_sensores.sv
// Bench for generador_sensores: directed and random sequences checked
// against a per-cycle trace built from the phase tables.
module tb_generador_sensores;

  localparam int H = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_entrada;
  logic       req_salida;
  logic       abortar;
  logic       a;
  logic       b;
  logic       ocupado;
  logic       fin;
  logic       abortado;
  logic [2:0] autos;

  int vectors = 0;
  int miscompares = 0;
  int ref_autos = 0;

  generador_sensores #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_entrada(req_entrada),
    .req_salida (req_salida),
    .abortar    (abortar),
    .a          (a),
    .b          (b),
    .ocupado    (ocupado),
    .fin        (fin),
    .abortado   (abortado),
    .autos      (autos)
  );

  always #5 clk = ~clk;

  // Entry order of {a,b}; an exit walks the same table backwards.
  function automatic logic [1:0] ph(input bit d, input int p);
    logic [1:0] ent [0:3];
    logic [1:0] idx;
    ent = '{2'b11, 2'b01, 2'b00, 2'b10};
    idx = 2'(d ? 4 - p : p);
    return ent[idx];
  endfunction

  function automatic logic [7:0] pk(
    input logic [1:0] ab, input bit oc, input bit f, input bit ab_p
  );
    return {ab, oc, f, ab_p, 3'(ref_autos)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {a, b, ocupado, fin, abortado, autos};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed={a,b,oc,fin,abt,autos}=%b required=%b",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. k=0: no abort; else abort in
  // phase k after o extra cycles of that phase.
  task automatic run_seq(input bit d, input int k, input int o,
                         input bit both, input string tag);
    logic [7:0] q[$];
    int idx_ab;
    int quiet;
    q = {};
    idx_ab = -1;
    if (k == 0) begin
      for (int p = 1; p <= 3; p++)
        for (int c = 0; c < H; c++) q.push_back(pk(ph(d, p), 1, 0, 0));
      if (!d && ref_autos < 7) ref_autos++;
      else if (d && ref_autos > 0) ref_autos--;
      q.push_back(pk(2'b11, 1, 1, 0));
      quiet = 3 * H - 1;
    end else begin
      for (int p = 1; p < k; p++)
        for (int c = 0; c < H; c++) q.push_back(pk(ph(d, p), 1, 0, 0));
      for (int c = 0; c <= o; c++) q.push_back(pk(ph(d, k), 1, 0, 0));
      idx_ab = (k - 1) * H + o;
      quiet = idx_ab;
      for (int p = k - 1; p >= 1; p--)
        for (int c = 0; c < H; c++) q.push_back(pk(ph(d, p), 1, 0, 0));
      q.push_back(pk(2'b11, 1, 0, 1));
    end
    for (int c = 1; c < G; c++) q.push_back(pk(2'b11, 1, 0, 0));
    q.push_back(pk(2'b11, 0, 0, 0));

    req_entrada = !d || both;
    req_salida  = d || both;
    abortar     = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), q[i]);
      if (i == q.size() - 1) begin
        req_entrada = 1'b0;
        req_salida  = 1'b0;
        abortar     = 1'b0;
      end else begin
        req_entrada = 1'($urandom_range(0, 1));
        req_salida  = 1'($urandom_range(0, 1));
        abortar = (i == idx_ab) ||
                  (i > quiet && 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_entrada = 1'b0;
    req_salida  = 1'b0;
    abortar     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", {2'b11, 1'b0, 1'b0, 1'b0, 3'd0});
    reset = 1'b0;
    @(negedge clk);
    chk("idle", {2'b11, 1'b0, 1'b0, 1'b0, 3'd0});

    run_seq(0, 0, 0, 0, "entry1");
    run_seq(1, 0, 0, 0, "exit_from1");
    run_seq(1, 0, 0, 0, "exit_at0");
    run_seq(0, 0, 0, 0, "entry_up");
    run_seq(1, 0, 0, 0, "exit_down");
    run_seq(0, 0, 0, 1, "both_req");
    for (int n = 0; n < 8; n++) run_seq(0, 0, 0, 0, $sformatf("sat%0d", n));
    run_seq(0, 3, 1, 0, "abort_f3");
    run_seq(1, 1, 0, 0, "abort_f1");
    run_seq(1, 2, H - 1, 0, "abort_f2_last");
    run_seq(1, 0, 0, 0, "exit_after_abort");

    for (int n = 0; n < 30; n++) begin
      bit d;
      int k;
      d = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      run_seq(d, k, int'($urandom_range(0, H - 1)),
              !d && 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // reset during FASE2 of an exit
    req_salida = 1'b1;
    for (int i = 0; i <= H + 1; i++) begin
      @(negedge clk);
      req_salida = 1'b0;
    end
    chk("pre_reset_f2", {2'b00, 1'b1, 1'b0, 1'b0, 3'(ref_autos)});
    reset = 1'b1;
    @(negedge clk);
    ref_autos = 0;
    chk("mid_reset", {2'b11, 1'b0, 1'b0, 1'b0, 3'd0});
    reset = 1'b0;
    run_seq(0, 0, 0, 0, "after_reset");
    for (int n = 0; n < 10; n++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      run_seq(d, int'($urandom_range(0, 3)), int'($urandom_range(0, H - 1)),
              0, $sformatf("tail%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
